// File: rtl/avg_pkg.sv
// Shared widths, saturation limits and the round/shift/saturate helper for the
// signed sum averager and its bench model.
package avg_pkg;

  localparam int unsigned SUM_W = 15;
  localparam int unsigned OUT_W = 12;
  localparam int unsigned SHIFT = 3;

  localparam int SAT_MAX_I = (2 ** (OUT_W - 1)) - 1;
  localparam int SAT_MIN_I = -(2 ** (OUT_W - 1));

  localparam logic signed [OUT_W-1:0] SAT_MAX = OUT_W'(SAT_MAX_I);
  localparam logic signed [OUT_W-1:0] SAT_MIN = OUT_W'(SAT_MIN_I);

  // Round half toward +inf at SUM_W+1 bits, arithmetic shift, then clamp.
  function automatic logic signed [OUT_W-1:0] round_shift_sat(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W:0] ext;
    logic signed [SUM_W:0] shf;
    int                    shf_i;
    ext   = $signed({s[SUM_W-1], s}) + $signed((SUM_W + 1)'(1 << (SHIFT - 1)));
    shf   = ext >>> SHIFT;
    shf_i = int'(shf);
    if (shf_i > SAT_MAX_I) begin
      return SAT_MAX;
    end else if (shf_i < SAT_MIN_I) begin
      return SAT_MIN;
    end
    return OUT_W'(shf_i);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with count-based full/empty; push while full is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/signed_sum_averager.sv
// Turns each 8-sample signed sum into a rounded, saturated mean and queues it
// for a valid/ready consumer, counting results lost to a full queue.
module signed_sum_averager
  import avg_pkg::*;
#(
  parameter int unsigned SUM_W = avg_pkg::SUM_W,
  parameter int unsigned OUT_W = avg_pkg::OUT_W,
  parameter int unsigned SHIFT = avg_pkg::SHIFT,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SUM_W-1:0] sum,
  input  logic             sum_valid,
  output logic [OUT_W-1:0] avg_out,
  output logic             avg_valid,
  input  logic             avg_ready,
  output logic             fifo_full,
  output logic [CNT_W-1:0] drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [OUT_W-1:0] stage_data;
  logic             stage_valid;
  logic [OUT_W-1:0] head;
  logic             q_full;
  logic             q_empty;
  logic [AW:0]      q_count;
  logic             pop;
  logic             drop;

  // Stage 1: mean of the incoming sum, registered with its qualifier.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
    end else begin
      stage_valid <= sum_valid;
      if (sum_valid) stage_data <= round_shift_sat(sum);
    end
  end

  assign pop  = avg_valid && avg_ready;
  assign drop = stage_valid && q_full && !pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (OUT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (stage_valid),
    .pop   (pop),
    .din   (stage_data),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign avg_valid = !q_empty;
  assign avg_out   = q_empty ? '0 : head;
  assign fifo_full = (q_count == (AW + 1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_signed_sum_averager.sv
// Directed bench for signed_sum_averager: table of single-result vectors plus
// hand-written sequences for throughput, overflow, full push/pop and reset.
module tb_signed_sum_averager;
  import avg_pkg::*;

  logic        clk;
  logic        rst;
  logic [14:0] sum;
  logic        sum_valid;
  logic [11:0] avg_out;
  logic        avg_valid;
  logic        avg_ready;
  logic        fifo_full;
  logic [7:0]  drop_count;

  int vec_count;
  int miscompares;

  typedef struct {
    logic [14:0] sum;
    logic [11:0] avg;
  } vec_t;

  vec_t vecs [15];

  signed_sum_averager dut (
    .clk        (clk),
    .rst        (rst),
    .sum        (sum),
    .sum_valid  (sum_valid),
    .avg_out    (avg_out),
    .avg_valid  (avg_valid),
    .avg_ready  (avg_ready),
    .fifo_full  (fifo_full),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    vec_count   = 0;
    miscompares = 0;

    vecs[0]  = '{15'd731,   12'h05B};
    vecs[1]  = '{15'd2613,  12'h147};
    vecs[2]  = '{15'd20,    12'h003};
    vecs[3]  = '{15'd12,    12'h002};
    vecs[4]  = '{15'h7FF4,  12'hFFF};   // -12
    vecs[5]  = '{15'h7FF8,  12'hFFF};   // -8
    vecs[6]  = '{15'h4000,  12'h800};   // -16384
    vecs[7]  = '{15'd16376, 12'h7FF};
    vecs[8]  = '{15'd16379, 12'h7FF};
    vecs[9]  = '{15'd16380, 12'h7FF};   // rounds to 2048, clamps
    vecs[10] = '{15'd16383, 12'h7FF};
    vecs[11] = '{15'h7FFC,  12'h000};   // -4 -> -0.5 rounds up to 0
    vecs[12] = '{15'h7FFB,  12'hFFF};   // -5
    vecs[13] = '{15'd4,     12'h001};
    vecs[14] = '{15'd3,     12'h000};

    rst       = 1'b1;
    sum       = '0;
    sum_valid = 1'b0;
    avg_ready = 1'b1;
    step();
    step();
    check("reset avg_valid", 32'(avg_valid), 32'd0);
    check("reset avg_out", 32'(avg_out), 32'd0);
    check("reset fifo_full", 32'(fifo_full), 32'd0);
    check("reset drop_count", 32'(drop_count), 32'd0);
    rst = 1'b0;
    step();

    // Single results: invisible one cycle after sum_valid, valid at two, gone at three.
    foreach (vecs[i]) begin
      sum       = vecs[i].sum;
      sum_valid = 1'b1;
      step();
      sum_valid = 1'b0;
      check($sformatf("vec%0d early valid", i), 32'(avg_valid), 32'd0);
      step();
      check($sformatf("vec%0d valid", i), 32'(avg_valid), 32'd1);
      check($sformatf("vec%0d avg_out", i), 32'(avg_out), 32'(vecs[i].avg));
      step();
      check($sformatf("vec%0d valid drop", i), 32'(avg_valid), 32'd0);
    end

    // Back-to-back sums at full throughput.
    for (int i = 0; i < 5; i++) begin
      sum_valid = (i < 3);
      sum       = 15'(8 * (i + 1));
      step();
      if (i >= 1 && i <= 3) begin
        check($sformatf("b2b valid %0d", i), 32'(avg_valid), 32'd1);
        check($sformatf("b2b out %0d", i), 32'(avg_out), 32'(i));
      end else begin
        check($sformatf("b2b idle %0d", i), 32'(avg_valid), 32'd0);
      end
    end
    sum_valid = 1'b0;

    // Overflow: six results into a stalled 4-deep queue.
    avg_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sum       = 15'(8 * (i + 1));
      sum_valid = 1'b1;
      step();
      check($sformatf("ovf full %0d", i), 32'(fifo_full), 32'(i >= 4));
    end
    sum_valid = 1'b0;
    step();
    step();
    check("ovf full after", 32'(fifo_full), 32'd1);
    check("ovf drop_count", 32'(drop_count), 32'd2);
    avg_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovf drain valid %0d", k), 32'(avg_valid), 32'd1);
      check($sformatf("ovf drain out %0d", k), 32'(avg_out), 32'(k));
      step();
    end
    check("ovf drained valid", 32'(avg_valid), 32'd0);
    check("ovf drained out", 32'(avg_out), 32'd0);
    check("ovf drained full", 32'(fifo_full), 32'd0);

    // Full queue with a push and pop on the same edge: nothing is dropped.
    avg_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sum       = 15'(8 * (i + 1));
      sum_valid = 1'b1;
      step();
    end
    sum_valid = 1'b0;
    check("pp full before", 32'(fifo_full), 32'd1);
    check("pp head before", 32'(avg_out), 32'd1);
    avg_ready = 1'b1;
    step();
    avg_ready = 1'b0;
    check("pp full after", 32'(fifo_full), 32'd1);
    check("pp drop_count", 32'(drop_count), 32'd2);
    check("pp head after", 32'(avg_out), 32'd2);
    step();
    check("pp still full", 32'(fifo_full), 32'd1);
    avg_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("pp drain out %0d", k), 32'(avg_out), 32'(k));
      step();
    end
    check("pp drained valid", 32'(avg_valid), 32'd0);

    // Reset with three queued, one in stage 1 and a sum presented during reset.
    avg_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sum       = 15'(8 * (i + 1));
      sum_valid = 1'b1;
      step();
    end
    check("rst pre valid", 32'(avg_valid), 32'd1);
    rst       = 1'b1;
    sum       = 15'd800;
    sum_valid = 1'b1;
    step();
    rst       = 1'b0;
    sum_valid = 1'b0;
    avg_ready = 1'b1;
    check("rst mid valid", 32'(avg_valid), 32'd0);
    check("rst mid out", 32'(avg_out), 32'd0);
    check("rst mid drop_count", 32'(drop_count), 32'd0);
    check("rst mid full", 32'(fifo_full), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst quiet %0d", i), 32'(avg_valid), 32'd0);
    end

    // Normal operation resumes after reset.
    sum       = 15'd731;
    sum_valid = 1'b1;
    step();
    sum_valid = 1'b0;
    step();
    check("post rst valid", 32'(avg_valid), 32'd1);
    check("post rst out", 32'(avg_out), 32'h05B);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
